// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 display write path.
//   FB_ROWS / FB_COLS : framebuffer geometry (one FB_COLS-bit word per row)
//   draw_state_t      : sprite/clear sequencer states
//   row_idx_t, col_idx_t, fb_word_t, addr_t : common field widths
package chip8_pkg;

  localparam int FB_ROWS = 32;
  localparam int FB_COLS = 64;

  typedef logic [4:0]  row_idx_t;
  typedef logic [5:0]  col_idx_t;
  typedef logic [63:0] fb_word_t;
  typedef logic [11:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_CLR,
    ST_DONE
  } draw_state_t;

endpackage

// File: rtl/chip8_sprite_mask.sv
// Combinational sprite-row mask generator.
// Places an 8-pixel sprite byte at column x0 of a framebuffer word
// (bit FB_COLS-1 = column 0).
//   x0          : start column
//   sprite_byte : sprite row, MSB is the leftmost pixel
//   mask        : FB_COLS-bit word with the sprite pixels set
// CLIP=1 drops pixels that run past the last column; CLIP=0 wraps them
// around to column 0.
module chip8_sprite_mask #(
  parameter int FB_COLS = 64,
  parameter bit CLIP    = 1'b1
) (
  input  logic [5:0]         x0,
  input  logic [7:0]         sprite_byte,
  output logic [FB_COLS-1:0] mask
);

  logic [FB_COLS-1:0] aligned;

  assign aligned = {sprite_byte, {(FB_COLS-8){1'b0}}};

  if (CLIP) begin : g_clip
    assign mask = aligned >> x0;
  end else begin : g_wrap
    // For x0=0 the left shift is by the full word width and yields zero,
    // so the plain right shift alone supplies the result.
    assign mask = (aligned >> x0) | (aligned << (FB_COLS - int'(x0)));
  end

endmodule

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 framebuffer writer.
// Executes DXYN sprite draws (XOR into the framebuffer with collision
// detection) and 00E0 clears, owning the write port of the display RAM.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   draw_start, cls_start : one-cycle start pulses, taken only when idle
//                           (draw_start has priority)
//   x_in, y_in, n_in, i_in: VX, VY, sprite height, sprite base address
//   busy, done            : operation in progress / one-cycle completion
//   collision             : VF result, valid with done, held until next draw
//   mem_addr, mem_rdata   : sprite byte fetch, data one cycle after address
//   fb_addr, fb_rdata     : framebuffer row read, data one cycle after address
//   fb_wdata, fb_we       : framebuffer row write
// Each visible sprite row takes two cycles: RD presents both addresses,
// WR consumes the returned byte and row word and writes the XORed row back.
module chip8_sprite_draw #(
  parameter int FB_ROWS = 32,
  parameter int FB_COLS = 64,
  parameter bit CLIP    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw_start,
  input  logic               cls_start,
  input  logic [7:0]         x_in,
  input  logic [7:0]         y_in,
  input  logic [3:0]         n_in,
  input  logic [11:0]        i_in,
  output logic               busy,
  output logic               done,
  output logic               collision,
  output logic [11:0]        mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic [4:0]         fb_addr,
  input  logic [FB_COLS-1:0] fb_rdata,
  output logic [FB_COLS-1:0] fb_wdata,
  output logic               fb_we
);
  import chip8_pkg::*;

  draw_state_t state;
  draw_state_t state_next;

  row_idx_t   row;
  row_idx_t   row_next;
  col_idx_t   x0;
  row_idx_t   y0;
  logic [3:0] n_q;
  addr_t      base;

  logic [FB_COLS-1:0] mask;
  logic [5:0]         y_reach;
  logic               hit;

  // Only VX[5:0] and VY[4:0] select a start position.
  logic unused_coord_bits;
  assign unused_coord_bits = &{1'b0, x_in[7:6], y_in[7:5]};

  chip8_sprite_mask #(
    .FB_COLS (FB_COLS),
    .CLIP    (CLIP)
  ) u_mask (
    .x0          (x0),
    .sprite_byte (mem_rdata),
    .mask        (mask)
  );

  assign row_next = row + row_idx_t'(1);
  // Unwrapped screen row of the next sprite line, for bottom-edge clipping.
  assign y_reach  = {1'b0, y0} + {1'b0, row_next};
  assign hit      = |(fb_rdata & mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      row       <= '0;
      x0        <= '0;
      y0        <= '0;
      n_q       <= '0;
      base      <= '0;
      collision <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (draw_start) begin
            x0        <= x_in[5:0];
            y0        <= y_in[4:0];
            n_q       <= n_in;
            base      <= i_in;
            row       <= '0;
            collision <= 1'b0;
          end else if (cls_start) begin
            row <= '0;
          end
        end
        ST_WR: begin
          row <= row_next;
          if (hit) begin
            collision <= 1'b1;
          end
        end
        ST_CLR: begin
          row <= row_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = '0;
    fb_addr    = '0;
    fb_wdata   = '0;
    fb_we      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (draw_start) begin
          state_next = (n_in == 4'd0) ? ST_DONE : ST_RD;
        end else if (cls_start) begin
          state_next = ST_CLR;
        end
      end

      ST_RD: begin
        busy       = 1'b1;
        mem_addr   = base + addr_t'(row);
        fb_addr    = y0 + row;
        state_next = ST_WR;
      end

      ST_WR: begin
        busy     = 1'b1;
        fb_addr  = y0 + row;
        fb_wdata = fb_rdata ^ mask;
        fb_we    = 1'b1;
        if (row_next == {1'b0, n_q}) begin
          state_next = ST_DONE;
        end else if (CLIP && (int'(y_reach) >= FB_ROWS)) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RD;
        end
      end

      ST_CLR: begin
        busy    = 1'b1;
        fb_addr = row;
        fb_we   = 1'b1;
        if (row == row_idx_t'(FB_ROWS - 1)) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Bench for chip8_sprite_draw: a clipping and a wrapping instance share all
// inputs; each has its own framebuffer RAM model. Results are compared with
// a pixel-level reference model of the draw/clear rules.
module tb_chip8_sprite_draw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, draw_start, cls_start;
  logic [7:0]  x_in, y_in;
  logic [3:0]  n_in;
  logic [11:0] i_in;

  logic        busy_c, done_c, coll_c, fb_we_c;
  logic [11:0] mem_addr_c;
  logic [7:0]  mem_rdata_c;
  logic [4:0]  fb_addr_c;
  logic [63:0] fb_rdata_c, fb_wdata_c;

  logic        busy_w, done_w, coll_w, fb_we_w;
  logic [11:0] mem_addr_w;
  logic [7:0]  mem_rdata_w;
  logic [4:0]  fb_addr_w;
  logic [63:0] fb_rdata_w, fb_wdata_w;

  chip8_sprite_draw #(.FB_ROWS(32), .FB_COLS(64), .CLIP(1'b1)) u_clip (
    .clk(clk), .reset(reset), .draw_start(draw_start), .cls_start(cls_start),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .busy(busy_c), .done(done_c), .collision(coll_c),
    .mem_addr(mem_addr_c), .mem_rdata(mem_rdata_c),
    .fb_addr(fb_addr_c), .fb_rdata(fb_rdata_c), .fb_wdata(fb_wdata_c), .fb_we(fb_we_c)
  );

  chip8_sprite_draw #(.FB_ROWS(32), .FB_COLS(64), .CLIP(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .draw_start(draw_start), .cls_start(cls_start),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .busy(busy_w), .done(done_w), .collision(coll_w),
    .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .fb_addr(fb_addr_w), .fb_rdata(fb_rdata_w), .fb_wdata(fb_wdata_w), .fb_we(fb_we_w)
  );

  // Standalone mask generator instances.
  logic [5:0]  mx;
  logic [7:0]  mb;
  logic [63:0] mk_c, mk_w;
  chip8_sprite_mask #(.FB_COLS(64), .CLIP(1'b1)) u_mask_c (.x0(mx), .sprite_byte(mb), .mask(mk_c));
  chip8_sprite_mask #(.FB_COLS(64), .CLIP(1'b0)) u_mask_w (.x0(mx), .sprite_byte(mb), .mask(mk_w));

  // Environment: main memory, framebuffers, event counters.
  logic [7:0]  mem [4096];
  bit   [63:0] fb_c [32];
  bit   [63:0] fb_w [32];
  logic [63:0] ref_c [32];
  logic [63:0] ref_w [32];
  logic        ref_coll_c, ref_coll_w;

  int cyc = 0;
  int wr_c = 0, wr_w = 0;
  int done_cnt_c = 0, done_cnt_w = 0;
  int last_done_c = 0, last_done_w = 0;
  int start_cyc;
  int errors = 0, checks = 0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    mem_rdata_c <= mem[mem_addr_c];
    mem_rdata_w <= mem[mem_addr_w];
    fb_rdata_c  <= fb_c[fb_addr_c];
    fb_rdata_w  <= fb_w[fb_addr_w];
    if (fb_we_c) begin
      fb_c[fb_addr_c] <= fb_wdata_c;
      wr_c <= wr_c + 1;
    end
    if (fb_we_w) begin
      fb_w[fb_addr_w] <= fb_wdata_w;
      wr_w <= wr_w + 1;
    end
  end

  always @(negedge clk) begin
    if (done_c) begin
      done_cnt_c  <= done_cnt_c + 1;
      last_done_c <= cyc;
    end
    if (done_w) begin
      done_cnt_w  <= done_cnt_w + 1;
      last_done_w <= cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pixel-level reference: column c of a row lives at bit 63-c.
  task automatic model_op(input bit clip, input bit is_cls, input logic [7:0] xb,
                          input logic [7:0] yb, input logic [3:0] n, input logic [11:0] ia,
                          output int exp_done, output int exp_wr);
    int x, y, yy, xx, vis;
    bit coll;
    logic [7:0] b;
    if (is_cls) begin
      for (int r = 0; r < 32; r++) begin
        if (clip) ref_c[r] = '0; else ref_w[r] = '0;
      end
      exp_done = 33;
      exp_wr   = 32;
      return;
    end
    coll = 1'b0;
    vis  = 0;
    x = int'(xb) % 64;
    y = int'(yb) % 32;
    for (int r = 0; r < int'(n); r++) begin
      yy = y + r;
      if (clip && yy >= 32) break;
      yy = yy % 32;
      vis++;
      b = mem[(int'(ia) + r) % 4096];
      for (int p = 0; p < 8; p++) begin
        if (b[7-p]) begin
          xx = x + p;
          if (!(clip && xx >= 64)) begin
            xx = xx % 64;
            if (clip) begin
              if (ref_c[yy][63-xx]) coll = 1'b1;
              ref_c[yy][63-xx] = ~ref_c[yy][63-xx];
            end else begin
              if (ref_w[yy][63-xx]) coll = 1'b1;
              ref_w[yy][63-xx] = ~ref_w[yy][63-xx];
            end
          end
        end
      end
    end
    if (clip) ref_coll_c = coll; else ref_coll_w = coll;
    exp_wr   = vis;
    exp_done = (n == 4'd0) ? 1 : 2 * vis + 1;
  endtask

  // Issue one operation on both DUTs and measure done cycle and write count.
  task automatic do_op(input bit is_cls, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] n, input logic [11:0] ia,
                       output int dc, output int dw, output int wc, output int ww);
    int sdc, sdw, swc, sww;
    sdc = done_cnt_c; sdw = done_cnt_w; swc = wr_c; sww = wr_w;
    @(negedge clk);
    draw_start = !is_cls;
    cls_start  = is_cls;
    x_in = x; y_in = y; n_in = n; i_in = ia;
    start_cyc = cyc;
    @(negedge clk);
    draw_start = 1'b0;
    cls_start  = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done_cnt_c > sdc && done_cnt_w > sdw) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    dc = (done_cnt_c - sdc == 1) ? last_done_c - start_cyc : -1;
    dw = (done_cnt_w - sdw == 1) ? last_done_w - start_cyc : -1;
    wc = wr_c - swc;
    ww = wr_w - sww;
  endtask

  task automatic fb_cmp(input string tag);
    int bc, bw;
    bc = 0; bw = 0;
    for (int r = 31; r >= 0; r--) begin
      if (fb_c[r] !== ref_c[r]) bc = r;
      if (fb_w[r] !== ref_w[r]) bw = r;
    end
    chk($sformatf("%s fb_clip row%0d", tag, bc), fb_c[bc], ref_c[bc]);
    chk($sformatf("%s fb_wrap row%0d", tag, bw), fb_w[bw], ref_w[bw]);
    chk({tag, " coll_clip"}, coll_c, ref_coll_c);
    chk({tag, " coll_wrap"}, coll_w, ref_coll_w);
  endtask

  typedef struct {
    bit          cls;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic [11:0] ia;
    logic [7:0]  bv;
    int          done_c, done_w, wr_c, wr_w;
    bit          coll_c, coll_w;
    int          row;
    logic [63:0] row_c, row_w;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int dc, dw, wc, ww, edc, edw, ewc, eww;
    int sdc, sdw;
    logic [63:0] em_c, em_w;
    bit is_cls;
    logic [7:0] rx, ry;
    logic [3:0] rn;
    logic [11:0] ri;

    reset = 1'b1; draw_start = 1'b0; cls_start = 1'b0;
    x_in = '0; y_in = '0; n_in = '0; i_in = '0;
    mx = '0; mb = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    for (int r = 0; r < 32; r++) begin ref_c[r] = '0; ref_w[r] = '0; end
    ref_coll_c = 1'b0; ref_coll_w = 1'b0;

    // Mask generator on its own, including the x0=63 edge.
    for (int t = 0; t < 20; t++) begin
      mx = (t == 0) ? 6'd63 : 6'($urandom);
      mb = (t == 0) ? 8'hC1 : 8'($urandom);
      #1;
      em_c = '0; em_w = '0;
      for (int p = 0; p < 8; p++) begin
        if (mb[7-p]) begin
          if (int'(mx) + p < 64) em_c[63 - (int'(mx) + p)] = 1'b1;
          em_w[63 - ((int'(mx) + p) % 64)] = 1'b1;
        end
      end
      chk($sformatf("mask_clip x%0d b%h", mx, mb), mk_c, em_c);
      chk($sformatf("mask_wrap x%0d b%h", mx, mb), mk_w, em_w);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst busy",     {busy_c, busy_w}, 2'b00);
    chk("rst done",     {done_c, done_w}, 2'b00);
    chk("rst coll",     {coll_c, coll_w}, 2'b00);
    chk("rst fb_we",    {fb_we_c, fb_we_w}, 2'b00);
    chk("rst fb_wdata", fb_wdata_c | fb_wdata_w, 64'h0);
    chk("rst addrs",    {fb_addr_c, fb_addr_w, mem_addr_c, mem_addr_w}, '0);
    reset = 1'b0;
    @(negedge clk);

    //            cls x      y      n  I       byte   dC dW wC wW  cC cW row rowC                   rowW
    vecs[0] = '{1'b0, 8'd0,  8'd0,  1, 12'h200, 8'hF0, 3, 3, 1, 1, 0, 0, 0,  64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000};
    vecs[1] = '{1'b0, 8'd0,  8'd0,  1, 12'h200, 8'hF0, 3, 3, 1, 1, 1, 1, 0,  64'h0,                  64'h0};
    vecs[2] = '{1'b0, 8'd60, 8'd30, 4, 12'h300, 8'hFF, 5, 9, 2, 4, 0, 0, 30, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_000F};
    vecs[3] = '{1'b1, 8'd0,  8'd0,  0, 12'h000, 8'h00, 33, 33, 32, 32, 0, 0, 1, 64'h0,               64'h0};
    vecs[4] = '{1'b0, 8'h45, 8'h21, 1, 12'h400, 8'h80, 3, 3, 1, 1, 0, 0, 1,  64'h0400_0000_0000_0000, 64'h0400_0000_0000_0000};
    vecs[5] = '{1'b0, 8'd3,  8'd3,  0, 12'h500, 8'hFF, 1, 1, 0, 0, 0, 0, 1,  64'h0400_0000_0000_0000, 64'h0400_0000_0000_0000};
    vecs[6] = '{1'b0, 8'd5,  8'd1,  1, 12'h400, 8'h80, 3, 3, 1, 1, 1, 1, 1,  64'h0,                  64'h0};
    vecs[7] = '{1'b0, 8'd0,  8'd31, 3, 12'h600, 8'h81, 3, 7, 1, 3, 0, 0, 0,  64'h0,                  64'h8100_0000_0000_0000};

    for (int v = 0; v < 8; v++) begin
      if (!vecs[v].cls) begin
        for (int r = 0; r < int'(vecs[v].n); r++) mem[(int'(vecs[v].ia) + r) % 4096] = vecs[v].bv;
      end
      do_op(vecs[v].cls, vecs[v].x, vecs[v].y, vecs[v].n, vecs[v].ia, dc, dw, wc, ww);
      model_op(1'b1, vecs[v].cls, vecs[v].x, vecs[v].y, vecs[v].n, vecs[v].ia, edc, ewc);
      model_op(1'b0, vecs[v].cls, vecs[v].x, vecs[v].y, vecs[v].n, vecs[v].ia, edw, eww);
      chk($sformatf("vec%0d done_cyc_clip", v), dc, vecs[v].done_c);
      chk($sformatf("vec%0d done_cyc_wrap", v), dw, vecs[v].done_w);
      chk($sformatf("vec%0d writes_clip", v), wc, vecs[v].wr_c);
      chk($sformatf("vec%0d writes_wrap", v), ww, vecs[v].wr_w);
      chk($sformatf("vec%0d coll_clip", v), coll_c, vecs[v].coll_c);
      chk($sformatf("vec%0d coll_wrap", v), coll_w, vecs[v].coll_w);
      chk($sformatf("vec%0d row%0d_clip", v, vecs[v].row), fb_c[vecs[v].row], vecs[v].row_c);
      chk($sformatf("vec%0d row%0d_wrap", v, vecs[v].row), fb_w[vecs[v].row], vecs[v].row_w);
      fb_cmp($sformatf("vec%0d", v));
    end

    // Reset during the WR of sprite row 2: that write lands, nothing after.
    for (int r = 0; r < 4; r++) mem[12'h700 + r] = 8'hAA;
    sdc = done_cnt_c; sdw = done_cnt_w;
    @(negedge clk);
    draw_start = 1'b1; x_in = 8'd8; y_in = 8'd4; n_in = 4'd4; i_in = 12'h700;
    @(negedge clk);
    draw_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst we_in_wr2", {fb_we_c, fb_we_w}, 2'b11);
    chk("midrst addr_in_wr2", {fb_addr_c, fb_addr_w}, {5'd6, 5'd6});
    reset = 1'b1;
    @(negedge clk);
    chk("midrst we_after", {fb_we_c, fb_we_w}, 2'b00);
    chk("midrst busy_after", {busy_c, busy_w}, 2'b00);
    chk("midrst coll_after", {coll_c, coll_w}, 2'b00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst no_done", (done_cnt_c - sdc) + (done_cnt_w - sdw), 64'd0);
    model_op(1'b1, 1'b0, 8'd8, 8'd4, 4'd3, 12'h700, edc, ewc);
    model_op(1'b0, 1'b0, 8'd8, 8'd4, 4'd3, 12'h700, edw, eww);
    ref_coll_c = 1'b0; ref_coll_w = 1'b0;
    fb_cmp("midrst");

    // Randomized operations against the reference model.
    for (int t = 0; t < 40; t++) begin
      is_cls = ($urandom_range(0, 9) == 0);
      rx = 8'($urandom); ry = 8'($urandom);
      rn = 4'($urandom); ri = 12'($urandom);
      do_op(is_cls, rx, ry, rn, ri, dc, dw, wc, ww);
      model_op(1'b1, is_cls, rx, ry, rn, ri, edc, ewc);
      model_op(1'b0, is_cls, rx, ry, rn, ri, edw, eww);
      chk($sformatf("rnd%0d done_cyc_clip", t), dc, edc);
      chk($sformatf("rnd%0d done_cyc_wrap", t), dw, edw);
      chk($sformatf("rnd%0d writes_clip", t), wc, ewc);
      chk($sformatf("rnd%0d writes_wrap", t), ww, eww);
      fb_cmp($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
